// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller and its arbiter:
// controller state encoding and the wait-state counter type.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } sram_state_t;

    localparam int WAIT_CNT_WIDTH = 4;

    typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_t;

endpackage

// File: rtl/sram_ctrl.sv
// Avalon-MM slave to asynchronous SRAM bridge with fixed read/write wait states.
// All SRAM pins come straight from flops; the pad tristate lives one level up.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] s_address,
    input  logic [BE_WIDTH-1:0]   s_byteenable,
    input  logic                  s_read,
    output logic [DATA_WIDTH-1:0] s_readdata,
    input  logic                  s_write,
    input  logic [DATA_WIDTH-1:0] s_writedata,
    output logic                  s_waitrequest,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [BE_WIDTH-1:0]   sram_be_n,
    output sram_state_t           dbg_state
);

    localparam wait_cnt_t RD_LOAD = wait_cnt_t'(READ_WAIT - 1);
    localparam wait_cnt_t WR_LOAD = wait_cnt_t'(WRITE_WAIT - 1);

    sram_state_t state;
    wait_cnt_t   wait_cnt;

    // Handshake: a request (s_read or s_write) is taken only in IDLE and is
    // finished in the single cycle where s_waitrequest=0 (ACK); the master must
    // hold its request until then, and address/data it changes meanwhile are
    // ignored because everything the SRAM sees was latched at acceptance.
    assign s_waitrequest = (state != ACK);
    assign dbg_state     = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            s_readdata  <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_be_n   <= '1;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous read and write is served as a read only.
                    if (s_read) begin
                        sram_addr  <= s_address;
                        sram_be_n  <= ~s_byteenable;
                        wait_cnt   <= RD_LOAD;
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= 1'b0;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        state      <= RD;
                    end else if (s_write) begin
                        sram_addr   <= s_address;
                        sram_be_n   <= ~s_byteenable;
                        sram_dq_out <= s_writedata;
                        wait_cnt    <= WR_LOAD;
                        sram_ce_n   <= 1'b0;
                        sram_oe_n   <= 1'b1;
                        sram_we_n   <= 1'b0;
                        sram_dq_oe  <= 1'b1;
                        state       <= WR;
                    end
                end
                RD: begin
                    if (wait_cnt == '0) begin
                        s_readdata <= sram_dq_in;
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        state      <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                WR: begin
                    // Data stays driven through ACK so it is held past the WE rising edge.
                    if (wait_cnt == '0) begin
                        sram_we_n <= 1'b1;
                        sram_ce_n <= 1'b1;
                        state     <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ACK: begin
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
